alu_flag_unit: RTL and testbench

Registered, parametrised status-flag generator for the ALU datapath. It takes each valid ALU result and produces the Z/N/C/V flags one cycle later. It also accumulates sticky flags until software clears them, and tracks consecutive zero results with a saturating run counter and a threshold alert. It generalises the combinational 6-bit zero detector to any width and adds sequential flag state.

---
 rtl/alu_flag_unit.sv | 133 +++++++++++++
 tb/tb_alu_flag_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// Registered Z/N/C/V flag generator with sticky flags and a saturating
// zero-result run counter that raises an alert at a programmable length.
module alu_flag_unit #(
    parameter int WIDTH      = 6,
    parameter int RUN_W      = 4,
    parameter int RUN_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             sticky_clr,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             flags_valid,
    output logic             sticky_z,
    output logic             sticky_c,
    output logic             sticky_v,
    output logic [RUN_W-1:0] zero_run,
    output logic             run_alert
);

    localparam logic [RUN_W-1:0] RUN_MAX   = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_THR_V = RUN_W'(RUN_THRESH);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             fv_q, fv_d;
    logic             sz_q, sz_d;
    logic             sc_q, sc_d;
    logic             sv_q, sv_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             alert_q, alert_d;
    logic             new_z_s;

    // Next-state logic; result is only looked at when in_valid is high.
    always_comb begin
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        fv_d    = 1'b0;
        sz_d    = sz_q;
        sc_d    = sc_q;
        sv_d    = sv_q;
        run_d   = run_q;
        new_z_s = 1'b0;
        if (in_valid) begin
            new_z_s = (result == {WIDTH{1'b0}});
            z_d     = new_z_s;
            n_d     = result[WIDTH-1];
            c_d     = carry_in;
            v_d     = ovf_in;
            fv_d    = 1'b1;
            if (new_z_s) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_ONE;
                end else begin
                    run_d = run_q;
                end
            end else begin
                run_d = {RUN_W{1'b0}};
            end
            // Clear takes effect before the current sample is merged in.
            if (sticky_clr) begin
                sz_d = new_z_s;
                sc_d = carry_in;
                sv_d = ovf_in;
            end else begin
                sz_d = sz_q | new_z_s;
                sc_d = sc_q | carry_in;
                sv_d = sv_q | ovf_in;
            end
        end else begin
            if (sticky_clr) begin
                sz_d = 1'b0;
                sc_d = 1'b0;
                sv_d = 1'b0;
            end else begin
                sz_d = sz_q;
                sc_d = sc_q;
                sv_d = sv_q;
            end
        end
        alert_d = (run_d >= RUN_THR_V);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            fv_q    <= 1'b0;
            sz_q    <= 1'b0;
            sc_q    <= 1'b0;
            sv_q    <= 1'b0;
            run_q   <= {RUN_W{1'b0}};
            alert_q <= 1'b0;
        end else begin
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            fv_q    <= fv_d;
            sz_q    <= sz_d;
            sc_q    <= sc_d;
            sv_q    <= sv_d;
            run_q   <= run_d;
            alert_q <= alert_d;
        end
    end

    assign z           = z_q;
    assign n           = n_q;
    assign c           = c_q;
    assign v           = v_q;
    assign flags_valid = fv_q;
    assign sticky_z    = sz_q;
    assign sticky_c    = sc_q;
    assign sticky_v    = sv_q;
    assign zero_run    = run_q;
    assign run_alert   = alert_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios plus random
// traffic compared against an arithmetic reference model.
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] result;
    logic       carry_in;
    logic       ovf_in;
    logic       sticky_clr;
    logic       z, n, c, v, flags_valid;
    logic       sticky_z, sticky_c, sticky_v;
    logic [3:0] zero_run;
    logic       run_alert;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_z, m_n, m_c, m_v, m_fv, m_sz, m_sc, m_sv, m_run;

    alu_flag_unit #(.WIDTH(6), .RUN_W(4), .RUN_THRESH(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .result(result),
        .carry_in(carry_in), .ovf_in(ovf_in), .sticky_clr(sticky_clr),
        .z(z), .n(n), .c(c), .v(v), .flags_valid(flags_valid),
        .sticky_z(sticky_z), .sticky_c(sticky_c), .sticky_v(sticky_v),
        .zero_run(zero_run), .run_alert(run_alert)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_fv = 0;
        m_sz = 0; m_sc = 0; m_sv = 0; m_run = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".z"}, int'(z), m_z);
        chk({tag, ".n"}, int'(n), m_n);
        chk({tag, ".c"}, int'(c), m_c);
        chk({tag, ".v"}, int'(v), m_v);
        chk({tag, ".fv"}, int'(flags_valid), m_fv);
        chk({tag, ".sz"}, int'(sticky_z), m_sz);
        chk({tag, ".sc"}, int'(sticky_c), m_sc);
        chk({tag, ".sv"}, int'(sticky_v), m_sv);
        chk({tag, ".run"}, int'(zero_run), m_run);
        chk({tag, ".alert"}, int'(run_alert), (m_run >= 3) ? 1 : 0);
    endtask

    // One clock: apply inputs, advance the model at the edge, check after it.
    task automatic step(input string tag, input bit vld, input int r,
                        input bit ci, input bit vi, input bit clr);
        int nz;
        in_valid   = vld;
        result     = vld ? 6'(r) : 6'bxxxxxx;
        carry_in   = ci;
        ovf_in     = vi;
        sticky_clr = clr;
        @(posedge clk);
        if (vld) begin
            nz   = (r == 0) ? 1 : 0;
            m_z  = nz;
            m_n  = (r >= 32) ? 1 : 0;
            m_c  = ci;
            m_v  = vi;
            m_fv = 1;
            m_run = nz ? ((m_run < 15) ? m_run + 1 : 15) : 0;
            if (clr) begin
                m_sz = nz; m_sc = ci; m_sv = vi;
            end else begin
                m_sz = m_sz | nz; m_sc = m_sc | ci; m_sv = m_sv | vi;
            end
        end else begin
            m_fv = 0;
            if (clr) begin
                m_sz = 0; m_sc = 0; m_sv = 0;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; result = 6'd0; carry_in = 1'b0;
        ovf_in = 1'b0; sticky_clr = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full sweep of result values, valid every cycle.
        for (int i = 0; i < 64; i++) step("sweep", 1'b1, i, 1'b0, 1'b0, 1'b0);

        // Single zero sample with carry, then idle hold.
        step("clr0", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step("hold_s", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("hold_z", int'(z), 1);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("hold_sc", int'(sticky_c), 1);

        // Zero run reaching the threshold, broken by a nonzero result.
        step("brk", 1'b1, 9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("run3", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("run3_alert", int'(run_alert), 1);
        step("run3_nz", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        chk("run3_reset", int'(zero_run), 0);

        // Saturation with idle cycles in the middle of the run.
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                step("sat_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
                step("sat_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
            end
            step("sat", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_15", int'(zero_run), 15);

        // Sticky clear coincident with a sample keeps that sample.
        step("stk_v", 1'b1, 7, 1'b0, 1'b1, 1'b0);
        step("stk_both", 1'b1, 7, 1'b1, 1'b0, 1'b1);
        chk("stk_sv0", int'(sticky_v), 0);
        chk("stk_sc1", int'(sticky_c), 1);
        step("stk_clr", 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges.
        step("pre_rst", 1'b1, 3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("pre_rst_z", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #1 rst_n = 1'b1;
        step("post_rst", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_run", int'(zero_run), 1);

        // Random traffic, biased toward zero results to exercise runs.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 63)) : 0;
            step("rand", 1'($urandom_range(0, 3) != 0), r,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
